pipelined_add_sub: RTL and testbench
====================================

// Module: pipelined_add_sub
// PURPOSE
//   Parametrised, pipelined adder/subtracter with valid/ready handshake, four arithmetic modes and
//   carry/overflow flags. Successor to the single-cycle 32-bit adder/subtracter. Sits between a
//   producer and a consumer that can each stall; the pipeline depth is set to meet timing at WIDTH.
// PARAMETERS
//   WIDTH   32  operand/result width in bits, >= 2
//   STAGES  2   pipeline register stages, 1..4; latency in cycles with no stall
// PORTS
//   clk        in   1      clock, all logic on rising edge
//   rstN       in   1      asynchronous active-low reset
//   in_valid   in   1      a, b, mode hold a transaction
//   in_ready   out  1      block accepts the transaction this cycle
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   mode       in   2      00 add, 01 sub (A-B), 10 signed saturating add, 11 signed saturating sub
//   out_valid  out  1      sum and flags hold a result
//   out_ready  in   1      consumer accepts the result this cycle
//   sum        out  WIDTH  result
//   carry      out  1      carry out of bit WIDTH-1 (sub: 1 = no borrow, i.e. A >= B unsigned)
//   overflow   out  1      signed overflow of the unsaturated result (set in all modes)
// BEHAVIOUR
//   Reset (rstN low, asynchronous): all stage valid bits 0 -> out_valid=0; sum=0, carry=0,
//     overflow=0. in_ready=1 as soon as reset is released. Data in flight is discarded.
//   Handshake: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
//     Once out_valid is asserted, sum/carry/overflow remain stable until the transfer completes.
//   Pipeline: STAGES registers, each with a valid bit. Stage k loads when it is empty or stage k+1
//     loads (for the last stage: when out_ready is high). in_ready = stage-0 load condition. This
//     is combinational from out_ready through the valid bits; it must not depend on in_valid.
//   Latency: a result accepted at edge N is visible at edge N+STAGES-1 (out_valid high in the
//     cycle after that edge) when out_ready is held high. Throughput: 1 transaction/cycle.
//   No bubbles: with out_ready high, back-to-back inputs produce back-to-back outputs.
//     With out_ready low, at most STAGES results are buffered, then in_ready drops.
//   Arithmetic: compute {carry, raw} = A + (B ^ {WIDTH{sub}}) + sub, with sub = mode[0].
//     overflow = (A[W-1] == Bx[W-1]) && (raw[W-1] != A[W-1]), where Bx is the operand after inversion.
//     Modes 00/01: sum = raw (wraps modulo 2^WIDTH).
//     Modes 10/11: if overflow, sum = A[W-1] ? 100..0 (most negative) : 011..1 (most positive);
//       otherwise sum = raw. carry and overflow are reported unchanged.
//     Arithmetic is completed in stage 0. Later stages are pure pipeline registers, so the tool
//       can retime them.
//   mode is sampled with its operands; changing mode between transactions needs no flush.
//   Simultaneous in/out transfer on a full pipeline is legal and keeps it full.
//   Reset asserted mid-stream: out_valid drops immediately (asynchronously). No partial results follow.
// TESTING
//   1 Reset: rstN low with in_valid high -> out_valid=0, sum=0; after release in_ready=1,
//     first result appears after STAGES cycles.
//   2 Wrap: WIDTH=32, mode 00, A=FFFF_FFFF, B=1 -> sum=0, carry=1, overflow=0;
//     mode 01, A=0, B=1 -> sum=FFFF_FFFF, carry=0.
//   3 Saturation: mode 10, A=7FFF_FFFF, B=1 -> sum=7FFF_FFFF, overflow=1;
//     mode 11, A=8000_0000, B=1 -> sum=8000_0000, overflow=1; mode 10, A=5, B=-3 -> 2, overflow=0.
//   4 Backpressure: stream 10 random transactions with out_ready low for cycles 3-8 ->
//     in_ready low after STAGES are buffered, no loss or duplicate, order preserved, outputs stable while stalled.
//   5 Throughput: out_ready=1, 100 back-to-back inputs -> 100 consecutive out_valid cycles
//     starting STAGES cycles after the first input; results match the reference model.
//   6 Mid-stream reset: pulse rstN low while 2 results are in flight -> out_valid=0 immediately,
//     no stale result after release; sweep STAGES=1..4 and WIDTH=8,32.

Source files
------------

// File: rtl/pipelined_add_sub.sv
// Pipelined adder/subtracter with wrap and signed-saturating modes plus carry/overflow flags.
// All arithmetic is done ahead of stage 0. The remaining stages only move results forward.
module pipelined_add_sub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    // Handshake: a word moves across a port on a rising edge where valid && ready.
    // A producer holds valid and its payload until that edge, and ready never depends on valid.

    // Packed per-stage payload: {sum, carry, overflow}
    localparam int PW = WIDTH + 2;

    logic             sub;
    logic [WIDTH-1:0] b_x;
    logic [WIDTH-1:0] raw;
    logic             raw_carry;
    logic             raw_ovf;
    logic [WIDTH-1:0] sat_val;
    logic [WIDTH-1:0] res_sum;
    logic [PW-1:0]    stage_in;

    always_comb begin
        sub                = mode[0];
        b_x                = b ^ {WIDTH{sub}};
        {raw_carry, raw}   = {1'b0, a} + {1'b0, b_x} + {{WIDTH{1'b0}}, sub};
        raw_ovf            = (a[WIDTH-1] == b_x[WIDTH-1]) && (raw[WIDTH-1] != a[WIDTH-1]);
        // Overflow can only occur with like-signed effective operands, so A's sign picks the rail
        sat_val            = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        res_sum            = (mode[1] && raw_ovf) ? sat_val : raw;
        stage_in           = {res_sum, raw_carry, raw_ovf};
    end

    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;
    logic [PW-1:0]     data_q [STAGES];
    logic [PW-1:0]     data_d [STAGES];
    logic [STAGES-1:0] stage_load;
    logic              all_full;

    // A stage may load when the output drains or any stage from it to the output holds a gap
    always_comb begin
        all_full   = 1'b1;
        stage_load = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            all_full      = all_full & valid_q[k];
            stage_load[k] = out_ready | ~all_full;
        end
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (stage_load[0]) begin
            valid_d[0] = in_valid;
            if (in_valid) begin
                data_d[0] = stage_in;
            end
        end
        for (int k = 1; k < STAGES; k++) begin
            if (stage_load[k]) begin
                valid_d[k] = valid_q[k-1];
                if (valid_q[k-1]) begin
                    data_d[k] = data_q[k-1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            valid_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    assign in_ready                = stage_load[0];
    assign out_valid               = valid_q[STAGES-1];
    assign {sum, carry, overflow}  = data_q[STAGES-1];

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Scoreboard bench for pipelined_add_sub: expected words are queued at input transfer
// and compared in order at output transfer, with occupancy and hold-stability tracking.
module tb_pipelined_add_sub;

    localparam int WIDTH  = 32;
    localparam int STAGES = 3;

    logic             clk;
    logic             rstN;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             overflow;

    pipelined_add_sub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rstN      (rstN),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry     (carry),
        .overflow  (overflow)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [WIDTH+1:0] exp_q[$];
    logic [WIDTH+1:0] got;
    logic [WIDTH+1:0] exp_word;
    logic [WIDTH+1:0] held_data;
    logic             held_valid = 1'b0;
    int               occ        = 0;
    int               max_occ    = 0;
    int               run_len    = 0;
    int               run_max    = 0;
    int               push_cyc   = 0;
    int               n_checks   = 0;
    int               n_bad      = 0;

    task automatic check_eq(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Reference model: exact signed/unsigned arithmetic in 64 bits, then clamp or wrap
    function automatic logic [WIDTH+1:0] ref_model(input logic [WIDTH-1:0] x,
                                                    input logic [WIDTH-1:0] y,
                                                    input logic [1:0] m);
        longint           sx, sy, r, maxv, minv;
        logic [63:0]      ux, uy;
        logic             c, v;
        logic [WIDTH-1:0] s;
        sx   = $signed(x);
        sy   = $signed(y);
        ux   = 64'(x);
        uy   = 64'(y);
        maxv = (longint'(1) <<< (WIDTH - 1)) - 1;
        minv = -(longint'(1) <<< (WIDTH - 1));
        if (m[0]) begin
            r = sx - sy;
            c = (ux >= uy);
        end else begin
            r = sx + sy;
            c = ((ux + uy) >> WIDTH) != 64'd0;
        end
        v = (r > maxv) || (r < minv);
        s = r[WIDTH-1:0];
        if (m[1] && v) s = (r > maxv) ? maxv[WIDTH-1:0] : minv[WIDTH-1:0];
        return {s, c, v};
    endfunction

    function automatic logic [WIDTH-1:0] rand_op();
        case ($urandom_range(0, 7))
            0:       return {1'b0, {(WIDTH-1){1'b1}}};
            1:       return {1'b1, {(WIDTH-1){1'b0}}};
            2:       return {WIDTH{1'b1}};
            3:       return '0;
            default: return WIDTH'($urandom);
        endcase
    endfunction

    // ---------------- driver tasks (entered and left at posedge+1) ----------------
    task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        input logic [1:0] m, input logic [WIDTH+1:0] e);
        in_valid = 1'b1;
        a        = x;
        b        = y;
        mode     = m;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(e);
                push_cyc = cyc;
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
        end
        check_eq("send_timeout", in_ready, 1);
    endtask

    task automatic send_rand();
        logic [WIDTH-1:0] x, y;
        logic [1:0]       m;
        x = rand_op();
        y = rand_op();
        m = 2'($urandom_range(0, 3));
        send(x, y, m, ref_model(x, y, m));
    endtask

    task automatic drain(input string tag);
        in_valid = 1'b0;
        for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(negedge clk);
        check_eq(tag, exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // ---------------- output monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (!rstN) begin
                held_valid = 1'b0;
                run_len    = 0;
            end else begin
                got = {sum, carry, overflow};
                if (held_valid) begin
                    check_eq("hold_valid", out_valid, 1);
                    check_eq("hold_data", got, held_data);
                end
                check_eq("in_ready", in_ready, out_ready || (occ < STAGES));
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check_eq("extra_out", out_valid, 0);
                    end else begin
                        exp_word = exp_q.pop_front();
                        check_eq("result", got, exp_word);
                    end
                end
                if (out_valid) begin
                    run_len++;
                    if (run_len > run_max) run_max = run_len;
                end else begin
                    run_len = 0;
                end
                held_valid = out_valid && !out_ready;
                held_data  = got;
                occ = occ + int'(in_valid && in_ready) - int'(out_valid && out_ready);
                if (occ > max_occ) max_occ = occ;
            end
        end
    end

    // ---------------- main sequence ----------------
    bit done_rand;

    initial begin
        rstN      = 1'b0;
        in_valid  = 1'b1;
        a         = WIDTH'($urandom);
        b         = WIDTH'($urandom);
        mode      = 2'b00;
        out_ready = 1'b1;

        // Reset with a pending input: nothing may come out
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_sum", sum, 0);
        check_eq("rst_carry", carry, 0);
        check_eq("rst_ovf", overflow, 0);
        @(posedge clk);
        #1;
        rstN     = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("rel_in_ready", in_ready, 1);
        check_eq("rel_out_valid", out_valid, 0);
        @(posedge clk);
        #1;

        // First-result latency
        send_rand();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        check_eq("latency", cyc - push_cyc, STAGES);
        drain("drain_latency");

        // Directed wrap and saturation corners
        send(32'hFFFF_FFFF, 32'h1, 2'b00, {32'h0000_0000, 1'b1, 1'b0});
        send(32'h0000_0000, 32'h1, 2'b01, {32'hFFFF_FFFF, 1'b0, 1'b0});
        send(32'h7FFF_FFFF, 32'h1, 2'b00, {32'h8000_0000, 1'b0, 1'b1});
        send(32'h7FFF_FFFF, 32'h1, 2'b10, {32'h7FFF_FFFF, 1'b0, 1'b1});
        send(32'h8000_0000, 32'h1, 2'b11, {32'h8000_0000, 1'b1, 1'b1});
        send(32'h0000_0005, 32'hFFFF_FFFD, 2'b10, {32'h0000_0002, 1'b1, 1'b0});
        drain("drain_directed");

        // Mixed modes back to back
        for (int i = 0; i < 20; i++) send_rand();
        drain("drain_mixed");

        // Backpressure window while streaming
        max_occ = 0;
        fork
            begin
                for (int i = 0; i < 10; i++) send_rand();
                in_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (6) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain("drain_backpressure");
        check_eq("bp_buffered", max_occ, STAGES);

        // Throughput: 100 inputs must give an unbroken 100-cycle output run
        run_max = 0;
        for (int i = 0; i < 100; i++) send_rand();
        drain("drain_throughput");
        check_eq("throughput_run", run_max, 100);

        // Random stalls on both sides
        done_rand = 1'b0;
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        in_valid = 1'b0;
                        @(posedge clk);
                        #1;
                    end
                    send_rand();
                end
                in_valid  = 1'b0;
                done_rand = 1'b1;
            end
            begin
                while (!done_rand) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain("drain_random");

        // Reset in the middle of a stalled stream
        out_ready = 1'b0;
        send_rand();
        send_rand();
        in_valid = 1'b0;
        repeat (STAGES) @(posedge clk);
        @(negedge clk);
        check_eq("mr_pre_valid", out_valid, 1);
        #2;
        rstN = 1'b0;
        #1;
        check_eq("mr_out_valid", out_valid, 0);
        check_eq("mr_sum", sum, 0);
        check_eq("mr_carry", carry, 0);
        check_eq("mr_ovf", overflow, 0);
        check_eq("mr_in_ready", in_ready, 1);
        exp_q.delete();
        occ        = 0;
        held_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstN      = 1'b1;
        out_ready = 1'b1;
        run_max   = 0;
        repeat (8) @(posedge clk);
        #1;
        check_eq("mr_no_stale", run_max, 0);
        send_rand();
        drain("drain_after_reset");

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
